// File: rtl/demux_pkg.sv
// Shared constants for the 1-to-4 byte demultiplexer and its slot counter.
package demux_pkg;
  localparam int LANES = 4;
  localparam int SLOT_W = 2;
  localparam int WIDTH_DEF = 8;
  localparam logic [SLOT_W-1:0] LAST_SLOT = 2'd3;
  // Reset value of every data bit; replicated to whatever WIDTH a lane uses.
  localparam logic DATA_RST_BIT = 1'b0;
endpackage

// File: rtl/demux_slot_counter.sv
// 2-bit free-running slot counter; slot 0 is the first cycle after reset drops.
module demux_slot_counter
  import demux_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  output logic [SLOT_W-1:0] slot,
  output logic              last_slot
);

  always_ff @(posedge clk) begin
    if (reset) slot <= '0;
    else       slot <= slot + 1'b1;
  end

  assign last_slot = (slot == LAST_SLOT);

endmodule

// File: rtl/demux_1x4.sv
// Redistributes an interleaved byte stream round-robin into four lanes,
// committing all lanes together at the end of each 4-slot frame.
module demux_1x4
  import demux_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int LANES = 4
) (
  input  logic             clk_4f,
  input  logic             reset,
  input  logic [WIDTH-1:0] Entrada,
  input  logic             validEntrada,
  output logic [WIDTH-1:0] Salida0,
  output logic [WIDTH-1:0] Salida1,
  output logic [WIDTH-1:0] Salida2,
  output logic [WIDTH-1:0] Salida3,
  output logic             validSalida0,
  output logic             validSalida1,
  output logic             validSalida2,
  output logic             validSalida3,
  output logic             frame_strobe
);

  localparam logic [WIDTH-1:0] DATA_RST = {WIDTH{DATA_RST_BIT}};

  logic [SLOT_W-1:0] slot;
  logic              last_slot;
  logic [WIDTH-1:0]  in_data;

  // Only lanes 0..2 are staged; lane 3 bypasses straight into the output.
  logic [WIDTH-1:0] stage_data  [LANES-1];
  logic             stage_valid [LANES-1];

  demux_slot_counter u_slot_counter (
    .clk       (clk_4f),
    .reset     (reset),
    .slot      (slot),
    .last_slot (last_slot)
  );

  // Invalid slots carry zero so stale bytes never reach a lane.
  assign in_data = validEntrada ? Entrada : DATA_RST;

  always_ff @(posedge clk_4f) begin
    if (reset) begin
      for (int i = 0; i < LANES - 1; i++) begin
        stage_data[i]  <= DATA_RST;
        stage_valid[i] <= 1'b0;
      end
      Salida0      <= DATA_RST;
      Salida1      <= DATA_RST;
      Salida2      <= DATA_RST;
      Salida3      <= DATA_RST;
      validSalida0 <= 1'b0;
      validSalida1 <= 1'b0;
      validSalida2 <= 1'b0;
      validSalida3 <= 1'b0;
      frame_strobe <= 1'b0;
    end else begin
      frame_strobe <= last_slot;
      if (last_slot) begin
        Salida0      <= stage_data[0];
        Salida1      <= stage_data[1];
        Salida2      <= stage_data[2];
        Salida3      <= in_data;
        validSalida0 <= stage_valid[0];
        validSalida1 <= stage_valid[1];
        validSalida2 <= stage_valid[2];
        validSalida3 <= validEntrada;
      end else begin
        case (slot)
          2'd0: begin
            stage_data[0]  <= in_data;
            stage_valid[0] <= validEntrada;
          end
          2'd1: begin
            stage_data[1]  <= in_data;
            stage_valid[1] <= validEntrada;
          end
          default: begin
            stage_data[2]  <= in_data;
            stage_valid[2] <= validEntrada;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_demux_1x4.sv
// Directed vector table plus randomized mux-to-demux loopback for demux_1x4.
module tb_demux_1x4;

  localparam int W = 37;  // {valid[3:0], data3..data0, strobe}

  logic       clk_4f = 1'b0;
  logic       reset;
  logic [7:0] Entrada;
  logic       validEntrada;
  logic [7:0] Salida0, Salida1, Salida2, Salida3;
  logic       validSalida0, validSalida1, validSalida2, validSalida3;
  logic       frame_strobe;

  int n_checks = 0;
  int n_pass   = 0;

  logic [W-1:0] exp_q[$];

  typedef struct {
    logic         rst;
    logic [7:0]   d;
    logic         v;
    logic [W-1:0] exp;
  } vec_t;

  vec_t vecs[$];

  demux_1x4 dut (
    .clk_4f       (clk_4f),
    .reset        (reset),
    .Entrada      (Entrada),
    .validEntrada (validEntrada),
    .Salida0      (Salida0),
    .Salida1      (Salida1),
    .Salida2      (Salida2),
    .Salida3      (Salida3),
    .validSalida0 (validSalida0),
    .validSalida1 (validSalida1),
    .validSalida2 (validSalida2),
    .validSalida3 (validSalida3),
    .frame_strobe (frame_strobe)
  );

  // Clock / reset
  always #5 clk_4f = ~clk_4f;

  function automatic logic [W-1:0] pack_out();
    return {validSalida3, validSalida2, validSalida1, validSalida0,
            Salida3, Salida2, Salida1, Salida0, frame_strobe};
  endfunction

  function automatic logic [W-1:0] mk_exp(logic [7:0] s3, logic [7:0] s2,
                                          logic [7:0] s1, logic [7:0] s0,
                                          logic [3:0] vm, logic st);
    return {vm, s3, s2, s1, s0, st};
  endfunction

  function automatic void add(logic rst, logic [7:0] d, logic v, logic [W-1:0] e);
    vec_t x;
    x.rst = rst; x.d = d; x.v = v; x.exp = e;
    vecs.push_back(x);
  endfunction

  // Driver: called at a negedge; applies inputs, lets one posedge pass,
  // returns at the following negedge where outputs are stable.
  task automatic cycle(input logic rst, input logic [7:0] d, input logic v);
    reset = rst; Entrada = d; validEntrada = v;
    @(posedge clk_4f);
    @(negedge clk_4f);
  endtask

  task automatic check(input string name, input logic [W-1:0] exp);
    logic [W-1:0] act;
    act = pack_out();
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  initial begin
    logic [W-1:0] z, fa, fs, fb1, fb2, fi;
    logic [W-1:0] last_exp, cur_exp;
    logic [7:0]   lane_d [4];
    logic         lane_v [4];

    reset = 1'b1; Entrada = '0; validEntrada = 1'b0;
    @(negedge clk_4f);

    z   = '0;
    fa  = mk_exp(8'hA3, 8'hA2, 8'hA1, 8'hA0, 4'hF, 1'b0);
    fs  = mk_exp(8'h13, 8'h12, 8'h00, 8'h10, 4'b1101, 1'b0);
    fb1 = mk_exp(8'h04, 8'h03, 8'h02, 8'h01, 4'hF, 1'b0);
    fb2 = mk_exp(8'h08, 8'h07, 8'h06, 8'h05, 4'hF, 1'b0);
    fi  = '0;

    // Reset state
    add(1, 8'hEE, 1, z);
    add(1, 8'hEE, 1, z);
    // Full valid frame
    add(0, 8'hA0, 1, z); add(0, 8'hA1, 1, z); add(0, 8'hA2, 1, z);
    add(0, 8'hA3, 1, fa | 1);
    // Sparse frame; A-frame must hold meanwhile
    add(0, 8'h10, 1, fa); add(0, 8'hFF, 0, fa); add(0, 8'h12, 1, fa);
    add(0, 8'h13, 1, fs | 1);
    // Back-to-back frames
    add(0, 8'h01, 1, fs); add(0, 8'h02, 1, fs); add(0, 8'h03, 1, fs);
    add(0, 8'h04, 1, fb1 | 1);
    add(0, 8'h05, 1, fb1); add(0, 8'h06, 1, fb1); add(0, 8'h07, 1, fb1);
    add(0, 8'h08, 1, fb2 | 1);
    // All-invalid frame still strobes
    add(0, 8'h55, 0, fb2); add(0, 8'h55, 0, fb2); add(0, 8'h55, 0, fb2);
    add(0, 8'h55, 0, fi | 1);
    // Reset mid-frame (slot 2), held across the would-be slot-3 edge
    add(0, 8'h30, 1, z); add(0, 8'h31, 1, z);
    add(1, 8'h32, 1, z); add(1, 8'h33, 1, z);
    add(0, 8'h20, 1, z); add(0, 8'h21, 1, z); add(0, 8'h22, 1, z);
    add(0, 8'h23, 1, mk_exp(8'h23, 8'h22, 8'h21, 8'h20, 4'hF, 1'b1));
    // Reset landing exactly on the slot-3 edge: no commit, no strobe
    add(0, 8'h40, 1, mk_exp(8'h23, 8'h22, 8'h21, 8'h20, 4'hF, 1'b0));
    add(0, 8'h41, 1, mk_exp(8'h23, 8'h22, 8'h21, 8'h20, 4'hF, 1'b0));
    add(0, 8'h42, 1, mk_exp(8'h23, 8'h22, 8'h21, 8'h20, 4'hF, 1'b0));
    add(1, 8'h43, 1, z);
    add(0, 8'h50, 0, z); add(0, 8'h51, 1, z); add(0, 8'h52, 0, z);
    add(0, 8'h53, 1, mk_exp(8'h53, 8'h00, 8'h51, 8'h00, 4'b1010, 1'b1));
    add(0, 8'h00, 0, mk_exp(8'h53, 8'h00, 8'h51, 8'h00, 4'b1010, 1'b0));

    for (int i = 0; i < vecs.size(); i++) begin
      cycle(vecs[i].rst, vecs[i].d, vecs[i].v);
      check($sformatf("vec%0d", i), vecs[i].exp);
    end

    // Randomized loopback: a behavioural mux sends lane k in slot k.
    cycle(1, 8'h00, 0);
    last_exp = '0;
    for (int f = 0; f < 1000; f++) begin
      for (int k = 0; k < 4; k++) begin
        lane_d[k] = 8'($urandom_range(0, 255));
        lane_v[k] = 1'($urandom_range(0, 1));
      end
      exp_q.push_back({lane_v[3], lane_v[2], lane_v[1], lane_v[0],
                       lane_v[3] ? lane_d[3] : 8'h00, lane_v[2] ? lane_d[2] : 8'h00,
                       lane_v[1] ? lane_d[1] : 8'h00, lane_v[0] ? lane_d[0] : 8'h00,
                       1'b0});
      for (int k = 0; k < 4; k++) begin
        cycle(0, lane_d[k], lane_v[k]);
        if (k < 3) begin
          check($sformatf("hold f%0d s%0d", f, k), last_exp);
        end else begin
          cur_exp  = exp_q.pop_front();
          check($sformatf("commit f%0d", f), cur_exp | 1);
          last_exp = cur_exp;
        end
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
